// File: rtl/sm_clk_ctrl_pkg.sv
// Shared encodings for the CPU clock sequencer: FSM states and mode-switch codes.
// Imported by sm_clk_ctrl and sm_edge_sync.
package sm_clk_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_HALT  = 2'b00,
        ST_RUN   = 2'b01,
        ST_STEP  = 2'b10,
        ST_BURST = 2'b11
    } state_e;

    localparam logic [1:0] MODE_RUN   = 2'b00;
    localparam logic [1:0] MODE_STEP  = 2'b01;
    localparam logic [1:0] MODE_BURST = 2'b10;

    // The prescaler only advances in the two free-running states.
    function automatic logic is_ticking(input state_e s);
        return (s == ST_RUN) || (s == ST_BURST);
    endfunction

endpackage

// File: rtl/sm_edge_sync.sv
// Two-flop synchronizer plus registered rising-edge detect for one board button.
// The edge pulse is one clk wide and appears three clk edges after the pin rises.
module sm_edge_sync
    import sm_clk_ctrl_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic level_in,
    output logic rise
);

    logic [2:0] sync_q, sync_d;
    logic [2:0] arm_q, arm_d;
    logic       rise_q, rise_d;

    // arm_q masks the detector until the history flop holds a real sample,
    // so a button held through reset never looks like a fresh press.
    always_comb begin
        sync_d = {sync_q[1:0], level_in};
        arm_d  = {arm_q[1:0], 1'b1};
        rise_d = sync_q[1] & ~sync_q[2] & arm_q[2];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            arm_q  <= '0;
            rise_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            arm_q  <= arm_d;
            rise_q <= rise_d;
        end
    end

    assign rise = rise_q;

endmodule

// File: rtl/sm_clk_ctrl.sv
// Run/step/burst sequencer producing a one-clk enable pulse for the CPU core.
// Optional breakpoint logic is built only when SM_CLK_CTRL_BREAKPOINT_EN is defined.
module sm_clk_ctrl
    import sm_clk_ctrl_pkg::*;
#(
    parameter int SHIFT   = 16,
    parameter int BURST_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         mode,
    input  logic [3:0]         divide,
    input  logic               startBtn,
    input  logic               stopBtn,
    input  logic               stepBtn,
    input  logic [BURST_W-1:0] burstLen,
    output logic               cpuClkEn,
    output logic               halted,
    output logic [31:0]        cycleCount
`ifdef SM_CLK_CTRL_BREAKPOINT_EN
    ,
    input  logic               bpEnable,
    input  logic [31:0]        bpAddr,
    input  logic [31:0]        pc,
    output logic               bpHit
`endif
);

    // One spare bit so the largest divide still fits its full count range.
    localparam int PRESC_W = SHIFT + 16;

    logic start_e, stop_e, step_e;

    sm_edge_sync u_start_sync (.clk(clk), .rst(rst), .level_in(startBtn), .rise(start_e));
    sm_edge_sync u_stop_sync  (.clk(clk), .rst(rst), .level_in(stopBtn),  .rise(stop_e));
    sm_edge_sync u_step_sync  (.clk(clk), .rst(rst), .level_in(stepBtn),  .rise(step_e));

    state_e               state_q, state_d;
    logic [PRESC_W-1:0]   presc_q, presc_d;
    logic [PRESC_W-1:0]   presc_limit;
    logic [BURST_W-1:0]   rem_q, rem_d;
    logic                 clk_en_q, clk_en_d;
    logic                 halted_q, halted_d;
    logic [31:0]          count_q, count_d;
    logic                 tick;
    logic                 bp_stop;
`ifdef SM_CLK_CTRL_BREAKPOINT_EN
    logic                 bp_hit_q, bp_hit_d;
`endif

    always_comb begin
        presc_limit = ~({PRESC_W{1'b1}} << (SHIFT + int'(divide)));
        tick        = is_ticking(state_q) && (presc_q == presc_limit);
`ifdef SM_CLK_CTRL_BREAKPOINT_EN
        bp_stop     = tick && bpEnable && (pc == bpAddr);
`else
        bp_stop     = 1'b0;
`endif
    end

    // Next-state logic: stop beats tick, and a breakpoint swallows the pulse it lands on.
    always_comb begin
        state_d  = state_q;
        rem_d    = rem_q;
        clk_en_d = 1'b0;
        presc_d  = tick ? '0 : presc_q + PRESC_W'(1);
`ifdef SM_CLK_CTRL_BREAKPOINT_EN
        bp_hit_d = bp_hit_q;
`endif

        case (state_q)
            ST_HALT: begin
                if (mode == MODE_RUN && start_e) begin
                    state_d = ST_RUN;
`ifdef SM_CLK_CTRL_BREAKPOINT_EN
                    bp_hit_d = 1'b0;
`endif
                end else if (mode == MODE_STEP && step_e) begin
                    state_d  = ST_STEP;
                    clk_en_d = 1'b1;
`ifdef SM_CLK_CTRL_BREAKPOINT_EN
                    bp_hit_d = 1'b0;
`endif
                end else if (mode == MODE_BURST && start_e && burstLen != '0) begin
                    state_d = ST_BURST;
                    rem_d   = burstLen;
`ifdef SM_CLK_CTRL_BREAKPOINT_EN
                    bp_hit_d = 1'b0;
`endif
                end
            end
            ST_RUN: begin
                if (stop_e) begin
                    state_d = ST_HALT;
                end else if (bp_stop) begin
                    state_d = ST_HALT;
`ifdef SM_CLK_CTRL_BREAKPOINT_EN
                    bp_hit_d = 1'b1;
`endif
                end else begin
                    clk_en_d = tick;
                end
            end
            ST_STEP: begin
                state_d = ST_HALT;
            end
            ST_BURST: begin
                if (stop_e) begin
                    state_d = ST_HALT;
                end else if (bp_stop) begin
                    state_d = ST_HALT;
`ifdef SM_CLK_CTRL_BREAKPOINT_EN
                    bp_hit_d = 1'b1;
`endif
                end else if (tick) begin
                    clk_en_d = 1'b1;
                    rem_d    = rem_q - BURST_W'(1);
                    if (rem_q == BURST_W'(1)) begin
                        state_d = ST_HALT;
                    end
                end
            end
            default: begin
                state_d = ST_HALT;
            end
        endcase

        // Prescaler restarts from zero on every entry into RUN/BURST and idles at zero otherwise.
        if (!is_ticking(state_d) || state_d != state_q) begin
            presc_d = '0;
        end

        halted_d = (state_d == ST_HALT);
        count_d  = clk_en_d ? count_q + 32'd1 : count_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_HALT;
            presc_q  <= '0;
            rem_q    <= '0;
            clk_en_q <= 1'b0;
            halted_q <= 1'b1;
            count_q  <= '0;
`ifdef SM_CLK_CTRL_BREAKPOINT_EN
            bp_hit_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            presc_q  <= presc_d;
            rem_q    <= rem_d;
            clk_en_q <= clk_en_d;
            halted_q <= halted_d;
            count_q  <= count_d;
`ifdef SM_CLK_CTRL_BREAKPOINT_EN
            bp_hit_q <= bp_hit_d;
`endif
        end
    end

    assign cpuClkEn   = clk_en_q;
    assign halted     = halted_q;
    assign cycleCount = count_q;
`ifdef SM_CLK_CTRL_BREAKPOINT_EN
    assign bpHit      = bp_hit_q;
`endif

endmodule

// File: tb/tb_sm_clk_ctrl.sv
// Directed bench for sm_clk_ctrl with SHIFT=0 and divide=1, so a tick lands every 2nd clk.
// Built against the default configuration (breakpoint ports absent).
module tb_sm_clk_ctrl;
    import sm_clk_ctrl_pkg::*;

    localparam int BTN_START = 0;
    localparam int BTN_STEP  = 1;
    localparam int BTN_STOP  = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  mode;
    logic [3:0]  divide;
    logic        startBtn, stopBtn, stepBtn;
    logic [7:0]  burstLen;
    logic        cpuClkEn;
    logic        halted;
    logic [31:0] cycleCount;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sm_clk_ctrl #(.SHIFT(0), .BURST_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .mode       (mode),
        .divide     (divide),
        .startBtn   (startBtn),
        .stopBtn    (stopBtn),
        .stepBtn    (stepBtn),
        .burstLen   (burstLen),
        .cpuClkEn   (cpuClkEn),
        .halted     (halted),
        .cycleCount (cycleCount)
    );

    typedef struct {
        logic [1:0] mode;
        logic [7:0] burst_len;
        int         btn;
        int         exp_pulses;
        logic       exp_halted;
        int         exp_count;
    } vec_t;

    vec_t vecs [10];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, required %0d", name, actual, expected);
        end
    endtask

    task automatic set_btn(input int btn, input logic val);
        case (btn)
            BTN_START: startBtn = val;
            BTN_STEP:  stepBtn  = val;
            default:   stopBtn  = val;
        endcase
    endtask

    // Counts enable pulses seen at negedges, plus the longest run of consecutive highs.
    task automatic run_cycles(input int n, output int pulses, output int max_run);
        int run;
        pulses  = 0;
        max_run = 0;
        run     = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (cpuClkEn) begin
                pulses++;
                run++;
                if (run > max_run) max_run = run;
            end else begin
                run = 0;
            end
        end
    endtask

    task automatic wait_pulse(input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (cpuClkEn) seen = 1'b1;
        end
    endtask

    task automatic press(input int btn);
        int p, m;
        set_btn(btn, 1'b1);
        run_cycles(4, p, m);
        set_btn(btn, 1'b0);
    endtask

    task automatic applyStimulus(input vec_t v, output int pulses, output int max_run);
        int p1, m1, p2, m2;
        mode     = v.mode;
        burstLen = v.burst_len;
        set_btn(v.btn, 1'b1);
        run_cycles(4, p1, m1);
        set_btn(v.btn, 1'b0);
        run_cycles(26, p2, m2);
        pulses  = p1 + p2;
        max_run = (m1 > m2) ? m1 : m2;
    endtask

    initial begin
        int   pulses, max_run, n, last, c0;
        bit   seen;

        vecs[0] = '{MODE_STEP,  8'd0, BTN_STEP,  1, 1'b1, 1};
        vecs[1] = '{MODE_STEP,  8'd0, BTN_STEP,  1, 1'b1, 2};
        vecs[2] = '{MODE_STEP,  8'd0, BTN_STEP,  1, 1'b1, 3};
        vecs[3] = '{MODE_BURST, 8'd5, BTN_START, 5, 1'b1, 8};
        vecs[4] = '{MODE_BURST, 8'd0, BTN_START, 0, 1'b1, 8};
        vecs[5] = '{MODE_RUN,   8'd0, BTN_STOP,  0, 1'b1, 8};
        vecs[6] = '{2'b11,      8'd3, BTN_START, 0, 1'b1, 8};
        vecs[7] = '{MODE_STEP,  8'd0, BTN_START, 0, 1'b1, 8};
        vecs[8] = '{MODE_BURST, 8'd1, BTN_START, 1, 1'b1, 9};
        vecs[9] = '{MODE_RUN,   8'd0, BTN_STEP,  0, 1'b1, 9};

        rst      = 1'b1;
        mode     = MODE_RUN;
        divide   = 4'd1;
        startBtn = 1'b1;
        stopBtn  = 1'b0;
        stepBtn  = 1'b0;
        burstLen = 8'd0;

        repeat (3) @(negedge clk);
        checkOutput("reset_halted", 32'(halted), 32'd1);
        checkOutput("reset_clken", 32'(cpuClkEn), 32'd0);
        checkOutput("reset_count", cycleCount, 32'd0);

        rst = 1'b0;
        run_cycles(12, pulses, max_run);
        checkOutput("held_through_reset_pulses", pulses, 0);
        checkOutput("held_through_reset_halted", 32'(halted), 32'd1);
        startBtn = 1'b0;
        run_cycles(4, pulses, max_run);

        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i], pulses, max_run);
            checkOutput($sformatf("vec%0d_pulses", i), pulses, vecs[i].exp_pulses);
            checkOutput($sformatf("vec%0d_halted", i), 32'(halted), 32'(vecs[i].exp_halted));
            checkOutput($sformatf("vec%0d_count", i), cycleCount, vecs[i].exp_count);
            if (vecs[i].exp_pulses > 0)
                checkOutput($sformatf("vec%0d_pulse_width", i), max_run, 1);
        end

        // RUN: ten pulses exactly two clk apart, then stop.
        mode     = MODE_RUN;
        startBtn = 1'b1;
        n        = 0;
        last     = -1;
        for (int c = 0; c < 200 && n < 10; c++) begin
            @(negedge clk);
            if (c == 4) startBtn = 1'b0;
            if (cpuClkEn) begin
                if (n > 0) checkOutput("run_spacing", c - last, 2);
                last = c;
                n++;
            end
        end
        startBtn = 1'b0;
        checkOutput("run_pulses", n, 10);
        checkOutput("run_count", cycleCount, 32'd19);
        checkOutput("run_not_halted", 32'(halted), 32'd0);
        press(BTN_STOP);
        run_cycles(10, pulses, max_run);
        c0 = int'(cycleCount);
        run_cycles(20, pulses, max_run);
        checkOutput("run_after_stop_pulses", pulses, 0);
        checkOutput("run_after_stop_halted", 32'(halted), 32'd1);
        checkOutput("run_after_stop_count", cycleCount, c0);

        // Stop edge landing on the same cycle as a tick: no pulse, HALT next cycle.
        press(BTN_START);
        wait_pulse(50, seen);
        checkOutput("svt_first_pulse_seen", 32'(seen), 32'd1);
        @(negedge clk);
        @(negedge clk);
        checkOutput("svt_prev_pulse", 32'(cpuClkEn), 32'd1);
        stopBtn = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checkOutput("svt_last_pulse", 32'(cpuClkEn), 32'd1);
        checkOutput("svt_running", 32'(halted), 32'd0);
        c0 = int'(cycleCount);
        @(negedge clk);
        @(negedge clk);
        checkOutput("svt_no_pulse", 32'(cpuClkEn), 32'd0);
        checkOutput("svt_halted", 32'(halted), 32'd1);
        checkOutput("svt_count", cycleCount, c0);
        stopBtn = 1'b0;
        run_cycles(10, pulses, max_run);

        // Reset in the middle of a long burst.
        mode     = MODE_BURST;
        burstLen = 8'd20;
        press(BTN_START);
        wait_pulse(50, seen);
        checkOutput("midburst_pulse_seen", 32'(seen), 32'd1);
        run_cycles(3, pulses, max_run);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("midburst_reset_clken", 32'(cpuClkEn), 32'd0);
        checkOutput("midburst_reset_halted", 32'(halted), 32'd1);
        checkOutput("midburst_reset_count", cycleCount, 32'd0);
        rst = 1'b0;
        run_cycles(40, pulses, max_run);
        checkOutput("midburst_no_resume", pulses, 0);
        checkOutput("midburst_still_halted", 32'(halted), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
